// File: rtl/instr_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : instr_ctrl_seq
// Purpose  : Multi-cycle control sequencer for the accumulator CPU. It accepts
//            one opcode per handshake, waits out the data-RAM read latency and
//            issues single-cycle write strobes.
// Revision : 1.0 - initial release
// ============================================================================
module instr_ctrl_seq #(
    parameter int OPW     = 5,
    parameter int RAM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic             acc_zero,
    output logic [1:0]       sel_a,
    output logic             sel_b,
    output logic             op,
    output logic             rd_ram,
    output logic             wr_ram,
    output logic             wr_acc,
    output logic             wr_pc,
    output logic             pc_src,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [4:0] c_HLT  = 5'd0;
    localparam logic [4:0] c_STO  = 5'd1;
    localparam logic [4:0] c_LD   = 5'd2;
    localparam logic [4:0] c_LDI  = 5'd3;
    localparam logic [4:0] c_ADD  = 5'd4;
    localparam logic [4:0] c_ADDI = 5'd5;
    localparam logic [4:0] c_SUB  = 5'd6;
    localparam logic [4:0] c_SUBI = 5'd7;
    localparam logic [4:0] c_BEQ  = 5'd8;
    localparam logic [4:0] c_BNE  = 5'd9;
    localparam logic [4:0] c_JMP  = 5'd10;

    localparam int                 c_LAT_W    = 3;
    localparam logic [c_LAT_W-1:0] c_LAT_LOAD = c_LAT_W'(RAM_LAT - 1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = '1;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        RD    = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_ready;
    logic [4:0]         r_opc5;
    logic               r_illegal;
    logic [1:0]         r_selA;
    logic               r_selB;
    logic               r_op;
    logic               r_rdRam;
    logic               r_wrRam;
    logic               r_wrAcc;
    logic               r_wrPc;
    logic               r_illPulse;
    logic               r_halted;
    logic [c_LAT_W-1:0] r_latCnt;
    logic [CNT_W-1:0]   r_cnt;

    logic [4:0] w_opc5;
    logic       w_upperSet;
    logic       w_inIllegal;
    logic       w_inRd;
    logic [1:0] w_inSelA;
    logic       w_inSelB;
    logic       w_inOp;

    assign w_opc5 = opcode[4:0];

    // Opcode bits above the decoded five only exist for OPW > 5.
    generate
        if (OPW > 5) begin : g_wideOpcode
            assign w_upperSet = |opcode[OPW-1:5];
        end else begin : g_narrowOpcode
            assign w_upperSet = 1'b0;
        end
    endgenerate

    always_comb begin
        w_inIllegal = w_upperSet || (w_opc5 > c_JMP);
        w_inRd      = !w_inIllegal && ((w_opc5 == c_LD) || (w_opc5 == c_ADD) || (w_opc5 == c_SUB));
        w_inSelA    = 2'b00;
        w_inSelB    = 1'b0;
        w_inOp      = 1'b0;
        if (!w_inIllegal) begin
            case (w_opc5)
                c_LDI:          w_inSelA = 2'b01;
                c_ADD, c_SUB:   w_inSelA = 2'b10;
                c_ADDI, c_SUBI: begin
                    w_inSelA = 2'b10;
                    w_inSelB = 1'b1;
                end
                default: ;
            endcase
            w_inOp = (w_opc5 == c_SUB) || (w_opc5 == c_SUBI);
        end
    end

    // EXEC strobes {wr_acc, wr_ram, wr_pc, illegal}; illegal opcodes act as NOP.
    function automatic logic [3:0] execStrobes(input logic [4:0] opc, input logic ill);
        logic wrAcc;
        logic wrRam;
        logic wrPc;
        wrAcc = !ill && (opc inside {c_LD, c_LDI, c_ADD, c_ADDI, c_SUB, c_SUBI});
        wrRam = !ill && (opc == c_STO);
        wrPc  = ill || (opc != c_HLT);
        return {wrAcc, wrRam, wrPc, ill};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= FETCH;
            r_ready    <= 1'b0;
            r_opc5     <= '0;
            r_illegal  <= 1'b0;
            r_selA     <= 2'b00;
            r_selB     <= 1'b0;
            r_op       <= 1'b0;
            r_rdRam    <= 1'b0;
            r_wrRam    <= 1'b0;
            r_wrAcc    <= 1'b0;
            r_wrPc     <= 1'b0;
            r_illPulse <= 1'b0;
            r_halted   <= 1'b0;
            r_latCnt   <= '0;
            r_cnt      <= '0;
        end else begin
            {r_wrAcc, r_wrRam, r_wrPc, r_illPulse} <= 4'b0000;
            case (r_state)
                FETCH: begin
                    r_ready <= 1'b1;
                    if (instr_valid && r_ready) begin
                        r_ready   <= 1'b0;
                        r_opc5    <= w_opc5;
                        r_illegal <= w_inIllegal;
                        r_selA    <= w_inSelA;
                        r_selB    <= w_inSelB;
                        r_op      <= w_inOp;
                        if (w_inRd) begin
                            r_state  <= RD;
                            r_rdRam  <= 1'b1;
                            r_latCnt <= c_LAT_LOAD;
                        end else begin
                            r_state <= EXEC;
                            {r_wrAcc, r_wrRam, r_wrPc, r_illPulse} <= execStrobes(w_opc5, w_inIllegal);
                        end
                    end
                end
                RD: begin
                    if (r_latCnt == '0) begin
                        r_state <= EXEC;
                        {r_wrAcc, r_wrRam, r_wrPc, r_illPulse} <= execStrobes(r_opc5, r_illegal);
                    end else begin
                        r_latCnt <= r_latCnt - c_LAT_W'(1);
                    end
                end
                EXEC: begin
                    r_rdRam <= 1'b0;
                    if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (!r_illegal && (r_opc5 == c_HLT)) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= FETCH;
                        r_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Branch decision uses acc_zero as seen during EXEC itself, hence combinational.
    assign pc_src = (r_state == EXEC) && !r_illegal &&
                    ((r_opc5 == c_JMP) ||
                     ((r_opc5 == c_BEQ) && acc_zero) ||
                     ((r_opc5 == c_BNE) && !acc_zero));

    assign instr_ready = r_ready;
    assign sel_a       = r_selA;
    assign sel_b       = r_selB;
    assign op          = r_op;
    assign rd_ram      = r_rdRam;
    assign wr_ram      = r_wrRam;
    assign wr_acc      = r_wrAcc;
    assign wr_pc       = r_wrPc;
    assign halted      = r_halted;
    assign illegal     = r_illPulse;
    assign instr_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_ctrl_seq.sv
`default_nettype none
// Bench for instr_ctrl_seq: instance A uses RAM_LAT=1/CNT_W=16, instance B uses
// RAM_LAT=3/CNT_W=4 so the longer read wait and counter saturation are reachable.
module tb_instr_ctrl_seq;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       accZero = 1'b0;
    logic [4:0] opcode  = 5'd0;
    logic       validA  = 1'b0;
    logic       validB  = 1'b0;

    logic        aReady, aSelB, aOp, aRdRam, aWrRam, aWrAcc, aWrPc, aPcSrc, aHalted, aIllegal;
    logic [1:0]  aSelA;
    logic [15:0] aCnt;
    logic        bReady, bSelB, bOp, bRdRam, bWrRam, bWrAcc, bWrPc, bPcSrc, bHalted, bIllegal;
    logic [1:0]  bSelA;
    logic [3:0]  bCnt;

    instr_ctrl_seq #(.OPW(5), .RAM_LAT(1), .CNT_W(16)) dutA (
        .clk(clk), .reset(reset), .instr_valid(validA), .instr_ready(aReady),
        .opcode(opcode), .acc_zero(accZero), .sel_a(aSelA), .sel_b(aSelB), .op(aOp),
        .rd_ram(aRdRam), .wr_ram(aWrRam), .wr_acc(aWrAcc), .wr_pc(aWrPc),
        .pc_src(aPcSrc), .halted(aHalted), .illegal(aIllegal), .instr_cnt(aCnt)
    );

    instr_ctrl_seq #(.OPW(5), .RAM_LAT(3), .CNT_W(4)) dutB (
        .clk(clk), .reset(reset), .instr_valid(validB), .instr_ready(bReady),
        .opcode(opcode), .acc_zero(accZero), .sel_a(bSelA), .sel_b(bSelB), .op(bOp),
        .rd_ram(bRdRam), .wr_ram(bWrRam), .wr_acc(bWrAcc), .wr_pc(bWrPc),
        .pc_src(bPcSrc), .halted(bHalted), .illegal(bIllegal), .instr_cnt(bCnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0] opc;
        logic       az;
        logic       rd;
        logic [1:0] selA;
        logic       selB;
        logic       op;
        logic       wrAcc;
        logic       wrRam;
        logic       pcSrc;
        logic       ill;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReadyA();
        int n = 0;
        while (aReady !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        chk("a_ready_wait", aReady, 1);
    endtask

    task automatic runVec(input int idx, input vec_t v, inout int expCnt);
        int lat;
        waitReadyA();
        validA  = 1'b1;
        opcode  = v.opc;
        accZero = v.az;
        step();
        validA = 1'b0;
        lat = 1;
        while (aWrPc !== 1'b1 && lat < 8) begin
            chk($sformatf("v%0d_rd_wait_rdram", idx), aRdRam, v.rd);
            step();
            lat++;
        end
        chk($sformatf("v%0d_latency", idx), lat, v.rd ? 2 : 1);
        chk($sformatf("v%0d_sel_a", idx), aSelA, v.selA);
        chk($sformatf("v%0d_sel_b", idx), aSelB, v.selB);
        chk($sformatf("v%0d_op", idx), aOp, v.op);
        chk($sformatf("v%0d_wr_acc", idx), aWrAcc, v.wrAcc);
        chk($sformatf("v%0d_wr_ram", idx), aWrRam, v.wrRam);
        chk($sformatf("v%0d_pc_src", idx), aPcSrc, v.pcSrc);
        chk($sformatf("v%0d_illegal", idx), aIllegal, v.ill);
        chk($sformatf("v%0d_exec_rd_ram", idx), aRdRam, v.rd);
        chk($sformatf("v%0d_exec_ready", idx), aReady, 0);
        step();
        expCnt++;
        chk($sformatf("v%0d_ready_after", idx), aReady, 1);
        chk($sformatf("v%0d_cnt", idx), aCnt, expCnt);
        chk($sformatf("v%0d_idle_strobes", idx), {aWrAcc, aWrRam, aWrPc, aIllegal, aRdRam, aPcSrc}, 0);
    endtask

    initial begin
        int expCnt;
        int hltBad;

        //            opc       az    rd    selA   selB  op    wrAcc wrRam pcSrc ill
        vecs[0]  = '{5'b00010, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; // LD
        vecs[1]  = '{5'b00011, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; // LDI
        vecs[2]  = '{5'b00100, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; // ADD
        vecs[3]  = '{5'b00101, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; // ADDI
        vecs[4]  = '{5'b00110, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // SUB
        vecs[5]  = '{5'b00111, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // SUBI
        vecs[6]  = '{5'b00001, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // STO
        vecs[7]  = '{5'b01000, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // BEQ taken
        vecs[8]  = '{5'b01000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // BEQ not taken
        vecs[9]  = '{5'b01001, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // BNE not taken
        vecs[10] = '{5'b01001, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // BNE taken
        vecs[11] = '{5'b01010, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // JMP
        vecs[12] = '{5'b01010, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // JMP
        vecs[13] = '{5'b01111, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // illegal
        vecs[14] = '{5'b11111, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // illegal
        vecs[15] = '{5'b01011, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // illegal

        // Reset state
        step();
        step();
        chk("a_reset_outs", {aReady, aSelA, aSelB, aOp, aRdRam, aWrRam, aWrAcc, aWrPc, aPcSrc, aHalted, aIllegal}, 0);
        chk("a_reset_cnt", aCnt, 0);
        chk("b_reset_outs", {bReady, bSelA, bSelB, bOp, bRdRam, bWrRam, bWrAcc, bWrPc, bPcSrc, bHalted, bIllegal}, 0);
        chk("b_reset_cnt", bCnt, 0);

        // LDI with valid held across the whole instruction
        reset  = 1'b0;
        validA = 1'b1;
        opcode = 5'b00011;
        step();
        chk("ldi_c1_ready", aReady, 1);
        chk("ldi_c1_wr_acc", aWrAcc, 0);
        step();
        chk("ldi_c2_wr_acc", aWrAcc, 1);
        chk("ldi_c2_wr_pc", aWrPc, 1);
        chk("ldi_c2_sel_a", aSelA, 2'b01);
        chk("ldi_c2_ready", aReady, 0);
        step();
        chk("ldi_c3_ready", aReady, 1);
        chk("ldi_c3_cnt", aCnt, 1);
        chk("ldi_c3_wr_acc", aWrAcc, 0);

        // Reset wins over a handshake in the same cycle
        opcode = 5'b00101;
        reset  = 1'b1;
        step();
        validA = 1'b0;
        reset  = 1'b0;
        chk("rstprio_ready", aReady, 0);
        chk("rstprio_sel", {aSelA, aSelB}, 0);
        chk("rstprio_cnt", aCnt, 0);
        step();
        chk("rstprio_wr_acc", aWrAcc, 0);
        chk("rstprio_ready_back", aReady, 1);

        expCnt = 0;
        for (int i = 0; i < 16; i++) begin
            runVec(i, vecs[i], expCnt);
        end

        // HLT: sticky halt, instr_valid ignored
        waitReadyA();
        validA = 1'b1;
        opcode = 5'b00000;
        step();
        chk("hlt_exec_strobes", {aWrAcc, aWrRam, aWrPc, aIllegal, aRdRam, aPcSrc}, 0);
        opcode = 5'b00011;
        step();
        expCnt++;
        chk("hlt_halted", aHalted, 1);
        chk("hlt_ready", aReady, 0);
        chk("hlt_cnt", aCnt, expCnt);
        hltBad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (aHalted !== 1'b1 || aReady !== 1'b0 ||
                {aWrAcc, aWrRam, aWrPc, aIllegal, aRdRam, aPcSrc} !== 6'd0) begin
                hltBad++;
            end
        end
        chk("hlt_hold_violations", hltBad, 0);
        chk("hlt_hold_cnt", aCnt, expCnt);
        validA = 1'b0;
        reset  = 1'b1;
        step();
        chk("hlt_rst_halted", aHalted, 0);
        chk("hlt_rst_cnt", aCnt, 0);
        reset = 1'b0;
        step();
        chk("hlt_rst_ready", aReady, 1);

        // RAM_LAT=3 ADD: rd_ram for four cycles, wr_acc only in the last
        opcode  = 5'b00100;
        accZero = 1'b0;
        validB  = 1'b1;
        step();
        validB = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("lat3_rd_ram_c%0d", k), bRdRam, 1);
            chk($sformatf("lat3_wr_acc_c%0d", k), bWrAcc, (k == 4) ? 1 : 0);
            chk($sformatf("lat3_ready_c%0d", k), bReady, 0);
            if (k == 4) begin
                chk("lat3_sels", {bSelA, bSelB, bOp}, 4'b1000);
            end
            step();
        end
        chk("lat3_rd_ram_end", bRdRam, 0);
        chk("lat3_ready_end", bReady, 1);
        chk("lat3_cnt", bCnt, 1);

        // Reset during RD of SUB: the pending wr_acc must never appear
        opcode = 5'b00110;
        validB = 1'b1;
        step();
        validB = 1'b0;
        chk("rdrst_rd1", bRdRam, 1);
        step();
        chk("rdrst_rd2", bRdRam, 1);
        chk("rdrst_rd2_wr_acc", bWrAcc, 0);
        reset = 1'b1;
        step();
        chk("rdrst_outs", {bReady, bSelA, bSelB, bOp, bRdRam, bWrRam, bWrAcc, bWrPc, bPcSrc, bHalted, bIllegal}, 0);
        chk("rdrst_cnt", bCnt, 0);
        reset = 1'b0;
        step();
        chk("rdrst_no_wr_acc", bWrAcc, 0);
        chk("rdrst_ready", bReady, 1);

        // Counter saturation on the 4-bit instance
        opcode = 5'b00011;
        for (int i = 0; i < 17; i++) begin
            int n = 0;
            while (bReady !== 1'b1 && n < 10) begin
                step();
                n++;
            end
            validB = 1'b1;
            step();
            validB = 1'b0;
            step();
            step();
            chk($sformatf("sat_cnt_%0d", i), bCnt, (i + 1 > 15) ? 15 : i + 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
